serial_word_loader: RTL and testbench

Deserializing front-end that assembles an N-bit word from a bit-serial input and drives the data input and load-enable input of the downstream N-bit load-enable register. It frames each word with a start strobe and an optional even-parity bit. It emits exactly one load pulse per good word. Bad-parity words are dropped and flagged.

---
 rtl/serial_word_loader.sv | 96 +++++++++
 tb/tb_serial_word_loader.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_loader.sv
// Bit-serial to parallel word assembler with optional even parity, driving the
// data and load-enable inputs of a downstream load-enable register.
module serial_word_loader #(
  parameter int N         = 8,
  parameter bit PARITY    = 1'b1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clock,
  input  logic         R,
  input  logic         start,
  input  logic         sin,
  input  logic         sin_valid,
  output logic [N-1:0] D_out,
  output logic         L_out,
  output logic         busy,
  output logic         parity_err
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_PARITY,
    S_LOAD
  } state_t;

  state_t         state_q;
  logic [N-1:0]   shift_q;
  logic [N-1:0]   shift_d;
  logic [CW-1:0]  count_q;
  logic           lastBit;

  assign shift_d = MSB_FIRST ? {shift_q[N-2:0], sin} : {sin, shift_q[N-1:1]};
  assign lastBit = (count_q == CW'(N - 1));

  // start outranks everything: it restarts the frame from any state, and a
  // pulse already on L_out still finishes because L_out is registered.
  always_ff @(posedge clock or posedge R) begin
    if (R) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      count_q    <= '0;
      D_out      <= '0;
      L_out      <= 1'b0;
      busy       <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      L_out <= 1'b0;
      if (start) begin
        state_q    <= S_SHIFT;
        shift_q    <= '0;
        count_q    <= '0;
        busy       <= 1'b1;
        parity_err <= 1'b0;
      end else begin
        case (state_q)
          S_SHIFT: begin
            if (sin_valid) begin
              shift_q <= shift_d;
              count_q <= count_q + 1'b1;
              if (lastBit) begin
                count_q <= '0;
                if (PARITY) begin
                  state_q <= S_PARITY;
                end else begin
                  state_q <= S_LOAD;
                  D_out   <= shift_d;
                  L_out   <= 1'b1;
                  busy    <= 1'b0;
                end
              end
            end
          end
          // Even parity: the received bit must equal the XOR of the data bits.
          S_PARITY: begin
            if (sin_valid) begin
              busy <= 1'b0;
              if (sin == ^shift_q) begin
                state_q <= S_LOAD;
                D_out   <= shift_q;
                L_out   <= 1'b1;
              end else begin
                state_q    <= S_IDLE;
                parity_err <= 1'b1;
              end
            end
          end
          S_LOAD:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_word_loader.sv
// Randomized bench for serial_word_loader: one MSB-first/parity instance (A)
// and one LSB-first/no-parity instance (B), checked against a word-level model.
module tb_serial_word_loader;

  logic       clock = 1'b0;
  logic       R;
  logic       startA, sinA, sinValidA;
  logic       startB, sinB, sinValidB;
  logic [7:0] dOutA, dOutB;
  logic       lOutA, busyA, perrA;
  logic       lOutB, busyB, perrB;

  always #5 clock = ~clock;

  serial_word_loader #(.N(8), .PARITY(1'b1), .MSB_FIRST(1'b1)) dutA (
    .clock(clock), .R(R), .start(startA), .sin(sinA), .sin_valid(sinValidA),
    .D_out(dOutA), .L_out(lOutA), .busy(busyA), .parity_err(perrA)
  );

  serial_word_loader #(.N(8), .PARITY(1'b0), .MSB_FIRST(1'b0)) dutB (
    .clock(clock), .R(R), .start(startB), .sin(sinB), .sin_valid(sinValidB),
    .D_out(dOutB), .L_out(lOutB), .busy(busyB), .parity_err(perrB)
  );

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int pulsesA = 0, pulsesB = 0, doubleA = 0, doubleB = 0;
  int expPulsesA = 0, expPulsesB = 0;
  logic prevLA = 1'b0, prevLB = 1'b0;
  int pulseCycA[$];
  logic [7:0] lastGoodA = 8'h00;

  always @(posedge clock) cycle++;

  // Independent pulse bookkeeping, sampled away from the active edge.
  always @(negedge clock) begin
    if (lOutA) begin
      pulsesA++;
      pulseCycA.push_back(cycle);
      if (prevLA) doubleA++;
    end
    if (lOutB) begin
      pulsesB++;
      if (prevLB) doubleB++;
    end
    prevLA = lOutA;
    prevLB = lOutB;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit toB, input logic st, input logic v, input logic b);
    @(negedge clock);
    if (toB) begin
      startB = st; sinValidB = v; sinB = b;
    end else begin
      startA = st; sinValidA = v; sinA = b;
    end
  endtask

  task automatic sendBit(input bit toB, input logic b, input int maxGap);
    int gap;
    gap = $urandom_range(0, maxGap);
    repeat (gap) applyStimulus(toB, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    applyStimulus(toB, 1'b0, 1'b1, b);
  endtask

  function automatic logic evenPar(input logic [7:0] w);
    return 1'($countones(w) % 2);
  endfunction

  // Serialize a word MSB-first and append a right or deliberately wrong parity bit.
  task automatic sendWordA(input logic [7:0] w, input bit goodPar);
    for (int i = 0; i < 8; i++) sendBit(1'b0, w[7-i], 2);
    sendBit(1'b0, goodPar ? evenPar(w) : ~evenPar(w), 2);
  endtask

  task automatic idle(input int n);
    @(negedge clock);
    startA = 0; sinValidA = 0; sinA = 0;
    startB = 0; sinValidB = 0; sinB = 0;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    logic [7:0] w;
    bit good;

    R = 0;
    startA = 0; sinA = 0; sinValidA = 0;
    startB = 0; sinB = 0; sinValidB = 0;
    #2 R = 1;
    repeat (2) @(negedge clock);
    checkOutput("rstD_A", dOutA, 0);
    checkOutput("rstL_A", lOutA, 0);
    checkOutput("rstBusyA", busyA, 0);
    checkOutput("rstPerrA", perrA, 0);
    checkOutput("rstD_B", dOutB, 0);
    checkOutput("rstL_B", lOutB, 0);
    R = 0;
    idle(1);

    // Reset in the middle of a frame, then orphan bits with no start.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) sendBit(1'b0, 1'b1, 1);
    @(negedge clock);
    R = 1;
    startA = 0; sinValidA = 0;
    #1;
    checkOutput("midRstBusy", busyA, 0);
    checkOutput("midRstL", lOutA, 0);
    checkOutput("midRstD", dOutA, 0);
    checkOutput("midRstPerr", perrA, 0);
    @(negedge clock);
    R = 0;
    for (int i = 0; i < 5; i++) sendBit(1'b0, 1'b1, 1);
    idle(3);
    checkOutput("orphanBusy", busyA, 0);
    checkOutput("orphanD", dOutA, 0);

    // Good frame A5 with correct parity.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("busyShift", busyA, 1);
    sendWordA(8'hA5, 1'b1);
    @(negedge clock);
    checkOutput("goodL", lOutA, 1);
    checkOutput("goodD", dOutA, 8'hA5);
    checkOutput("goodPerr", perrA, 0);
    checkOutput("goodBusyLoad", busyA, 0);
    expPulsesA++;
    lastGoodA = 8'hA5;
    idle(0);
    checkOutput("goodLEnd", lOutA, 0);

    // Same frame with wrong parity is dropped and flagged.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    w = 8'hA5;
    sendWordA(w, 1'b0);
    @(negedge clock);
    checkOutput("badL", lOutA, 0);
    checkOutput("badPerr", perrA, 1);
    checkOutput("badDHeld", dOutA, 8'hA5);
    checkOutput("badBusy", busyA, 0);
    idle(2);
    checkOutput("perrSticky", perrA, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clock);
    checkOutput("perrCleared", perrA, 0);

    // Abort after 4 bits; the restart edge carries a valid bit that must be dropped.
    for (int i = 0; i < 4; i++) sendBit(1'b0, 1'($urandom_range(0, 1)), 2);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    sendWordA(8'h3C, 1'b1);
    @(negedge clock);
    checkOutput("abortL", lOutA, 1);
    checkOutput("abortD", dOutA, 8'h3C);
    expPulsesA++;
    lastGoodA = 8'h3C;
    idle(1);

    // Random words, mostly good parity, against the word-level model.
    for (int k = 0; k < 16; k++) begin
      w = 8'($urandom);
      good = ($urandom_range(0, 3) != 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      sendWordA(w, good);
      @(negedge clock);
      checkOutput("rndL", lOutA, 32'(good));
      checkOutput("rndPerr", perrA, 32'(!good));
      if (good) begin
        lastGoodA = w;
        expPulsesA++;
      end
      checkOutput("rndD", dOutA, lastGoodA);
      idle($urandom_range(0, 2));
    end

    // Back-to-back: start during the LOAD cycle of A5, then 5A.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    sendWordA(8'hA5, 1'b1);
    @(negedge clock);
    checkOutput("b2bL1", lOutA, 1);
    checkOutput("b2bD1", dOutA, 8'hA5);
    startA = 1; sinValidA = 0;
    sendWordA(8'h5A, 1'b1);
    @(negedge clock);
    checkOutput("b2bL2", lOutA, 1);
    checkOutput("b2bD2", dOutA, 8'h5A);
    expPulsesA += 2;
    idle(2);
    if (pulseCycA.size() >= 2)
      checkOutput("b2bGapOk", 32'((pulseCycA[$] - pulseCycA[$-1]) >= 9), 1);
    else
      checkOutput("b2bPulses", pulseCycA.size(), 2);

    // LSB-first, no parity: 8'h01 with no gaps, pulse right after bit 8.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    w = 8'h01;
    for (int i = 0; i < 8; i++) sendBit(1'b1, w[i], 0);
    @(negedge clock);
    checkOutput("lsbL", lOutB, 1);
    checkOutput("lsbD", dOutB, 8'h01);
    checkOutput("lsbBusy", busyB, 0);
    expPulsesB++;
    idle(0);
    checkOutput("lsbLEnd", lOutB, 0);

    for (int k = 0; k < 8; k++) begin
      w = 8'($urandom);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) sendBit(1'b1, w[i], 2);
      @(negedge clock);
      checkOutput("rndBL", lOutB, 1);
      checkOutput("rndBD", dOutB, w);
      checkOutput("rndBPerr", perrB, 0);
      expPulsesB++;
      idle($urandom_range(0, 2));
    end

    idle(3);
    #1;
    checkOutput("pulseCountA", pulsesA, expPulsesA);
    checkOutput("pulseCountB", pulsesB, expPulsesB);
    checkOutput("doubleLA", doubleA, 0);
    checkOutput("doubleLB", doubleB, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: got cycle %0d expected completion", cycle);
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
